// File: rtl/buzzer_sched_if.sv
// Request/grant/speaker signal bundle between front-panel logic and buzzer_sched.
// master = requester side, slave = the scheduler.
interface buzzer_sched_if;
    logic       en;
    logic [2:0] req;
    logic [2:0] grant;
    logic       busy;
    logic       sp;

    modport master (
        output en,
        output req,
        input  grant,
        input  busy,
        input  sp
    );

    modport slave (
        input  en,
        input  req,
        output grant,
        output busy,
        output sp
    );
endinterface

// File: rtl/buzzer_sched.sv
// buzzer_sched: arbitrates alarm / steady tone / key beep onto one piezo pin.
// Define BUZZ_ALARM_GAP_EN for a 4-phase alarm (high, silent, low, silent).
module buzzer_sched #(
    parameter int unsigned TONE_HI_HALF = 28026,
    parameter int unsigned TONE_LO_HALF = 56053,
    parameter int unsigned SLOT_CYC     = 6250000,
    parameter int unsigned BEEP_SLOTS   = 1
) (
    input logic           clk,
    input logic           rst_n,
    buzzer_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALARM,
        S_STEADY,
        S_BEEP
    } state_t;

    localparam logic [31:0] HI_LAST   = 32'(TONE_HI_HALF - 1);
    localparam logic [31:0] LO_LAST   = 32'(TONE_LO_HALF - 1);
    localparam logic [31:0] SLOT_LAST = 32'(SLOT_CYC - 1);
    localparam logic [31:0] BEEP_LAST = 32'(BEEP_SLOTS - 1);
`ifdef BUZZ_ALARM_GAP_EN
    localparam logic [31:0] ALARM_LAST = 32'd3;
`else
    localparam logic [31:0] ALARM_LAST = 32'd1;
`endif

    state_t      state_q, state_d;
    logic [31:0] tone_q, tone_d;
    logic [31:0] slot_q, slot_d;
    logic [31:0] phase_q, phase_d;
    logic        tone_bit_q, tone_bit_d;
    logic        sp_q, sp_d;
    logic        req0_q;
    logic        pend_q, pend_d;

    logic        rise;
    logic        slot_wrap;
    logic        beep_done;
    logic        restart;
    logic        silent;
    logic [31:0] half_last;
    logic [31:0] phase_last;

    assign rise      = bus.req[0] & ~req0_q;
    assign slot_wrap = (slot_q == SLOT_LAST);
    assign beep_done = (state_q == S_BEEP) && slot_wrap && (phase_q == BEEP_LAST);

    // A completing beep clears the latch, but a trigger edge on that same
    // cycle re-arms it so the next beep follows with no idle gap.
    always_comb begin
        pend_d = pend_q | rise;
        if (beep_done) begin
            pend_d = rise;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        if (bus.req[2]) begin
            state_d = S_ALARM;
        end else if (bus.req[1]) begin
            state_d = S_STEADY;
        end else if (pend_d) begin
            state_d = S_BEEP;
        end
    end

    assign restart = (state_d != state_q) || beep_done;

    // Tone and phase selection for the current state.
    always_comb begin
        half_last  = HI_LAST;
        silent     = 1'b0;
        phase_last = '0;
        case (state_q)
            S_ALARM: begin
                phase_last = ALARM_LAST;
`ifdef BUZZ_ALARM_GAP_EN
                case (phase_q[1:0])
                    2'd0:    half_last = HI_LAST;
                    2'd2:    half_last = LO_LAST;
                    default: silent    = 1'b1;
                endcase
`else
                half_last = phase_q[0] ? LO_LAST : HI_LAST;
`endif
            end
            S_STEADY: half_last  = LO_LAST;
            S_BEEP:   phase_last = BEEP_LAST;
            default:  silent     = 1'b1;
        endcase
    end

    always_comb begin
        tone_d     = tone_q;
        slot_d     = slot_q;
        phase_d    = phase_q;
        tone_bit_d = tone_bit_q;
        if (restart || (state_q == S_IDLE)) begin
            tone_d     = '0;
            slot_d     = '0;
            phase_d    = '0;
            tone_bit_d = 1'b0;
        end else if (slot_wrap) begin
            tone_d     = '0;
            slot_d     = '0;
            tone_bit_d = 1'b0;
            phase_d    = (phase_q == phase_last) ? '0 : phase_q + 32'd1;
        end else begin
            slot_d = slot_q + 32'd1;
            if (silent) begin
                tone_d     = '0;
                tone_bit_d = 1'b0;
            end else if (tone_q == half_last) begin
                tone_d     = '0;
                tone_bit_d = ~tone_bit_q;
            end else begin
                tone_d = tone_q + 32'd1;
            end
        end
    end

    // sp follows the next tone bit so the first rise lands H edges after a state change.
    assign sp_d = tone_bit_d & bus.en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tone_q     <= '0;
            slot_q     <= '0;
            phase_q    <= '0;
            tone_bit_q <= 1'b0;
            sp_q       <= 1'b0;
            req0_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tone_q     <= tone_d;
            slot_q     <= slot_d;
            phase_q    <= phase_d;
            tone_bit_q <= tone_bit_d;
            sp_q       <= sp_d;
            req0_q     <= bus.req[0];
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        bus.grant = 3'b000;
        case (state_q)
            S_ALARM:  bus.grant = 3'b100;
            S_STEADY: bus.grant = 3'b010;
            S_BEEP:   bus.grant = 3'b001;
            default:  bus.grant = 3'b000;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.sp   = sp_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// Directed self-checking bench for buzzer_sched with shortened tone/slot timing.
// Honours BUZZ_ALARM_GAP_EN when computing the expected alarm pattern.
module tb_buzzer_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    buzzer_sched_if bus ();

    buzzer_sched #(
        .TONE_HI_HALF(4),
        .TONE_LO_HALF(8),
        .SLOT_CYC    (64),
        .BEEP_SLOTS  (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // k = edges since the source was granted (sample taken after that edge)
    function automatic logic hi_sp(input int k);
        return 1'((k / 4) % 2);
    endfunction

    function automatic logic lo_sp(input int k);
        return 1'((k / 8) % 2);
    endfunction

    function automatic logic alarm_sp(input int k);
        int m;
        m = k % 64;
`ifdef BUZZ_ALARM_GAP_EN
        case ((k / 64) % 4)
            0:       return hi_sp(m);
            2:       return lo_sp(m);
            default: return 1'b0;
        endcase
`else
        return (((k / 64) % 2) == 0) ? hi_sp(m) : lo_sp(m);
`endif
    endfunction

    initial begin
        bus.en  = 1'b1;
        bus.req = 3'b000;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 3'b000);
        chk("rst_busy", 3'(bus.busy), 3'd0);
        chk("rst_sp", 3'(bus.sp), 3'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_grant", bus.grant, 3'b000);

        // single beep
        bus.req = 3'b001;
        @(negedge clk);
        bus.req = 3'b000;
        for (int k = 0; k < 128; k++) begin
            chk("beep_grant", bus.grant, 3'b001);
            chk("beep_sp", 3'(bus.sp), 3'(hi_sp(k)));
            @(negedge clk);
        end
        chk("beep_end_grant", bus.grant, 3'b000);
        chk("beep_end_busy", 3'(bus.busy), 3'd0);
        chk("beep_end_sp", 3'(bus.sp), 3'd0);

        // alarm and steady together -> alarm; then priority falls to steady
        bus.req = 3'b110;
        @(negedge clk);
        chk("both_grant", bus.grant, 3'b100);
        chk("both_busy", 3'(bus.busy), 3'd1);
        bus.req = 3'b010;
        @(negedge clk);
        chk("alarm_drop_grant", bus.grant, 3'b010);
        chk("alarm_drop_sp", 3'(bus.sp), 3'd0);
        bus.req = 3'b000;
        @(negedge clk);
        chk("steady_drop_grant", bus.grant, 3'b000);

        // alarm pattern, then asynchronous reset mid-alarm
        bus.req = 3'b100;
        @(negedge clk);
        for (int k = 0; k < 260; k++) begin
            chk("alarm_grant", bus.grant, 3'b100);
            chk("alarm_sp", 3'(bus.sp), 3'(alarm_sp(k)));
            @(negedge clk);
        end
        chk("alarm_pre_rst_sp", 3'(bus.sp), 3'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", bus.grant, 3'b000);
        chk("async_rst_busy", 3'(bus.busy), 3'd0);
        chk("async_rst_sp", 3'(bus.sp), 3'd0);
        bus.req = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_grant", bus.grant, 3'b000);
            chk("post_rst_sp", 3'(bus.sp), 3'd0);
        end

        // steady preempts a beep at cycle 30; beep restarts afterwards
        bus.req = 3'b001;
        @(negedge clk);
        bus.req = 3'b000;
        for (int k = 0; k < 30; k++) begin
            chk("pre_beep_sp", 3'(bus.sp), 3'(hi_sp(k)));
            @(negedge clk);
        end
        bus.req = 3'b010;
        @(negedge clk);
        for (int j = 0; j < 100; j++) begin
            chk("preempt_grant", bus.grant, 3'b010);
            chk("preempt_sp", 3'(bus.sp), 3'(lo_sp(j)));
            if (j == 99) bus.req = 3'b000;
            @(negedge clk);
        end
        for (int k = 0; k < 128; k++) begin
            chk("rebeep_grant", bus.grant, 3'b001);
            chk("rebeep_sp", 3'(bus.sp), 3'(hi_sp(k)));
            @(negedge clk);
        end
        chk("rebeep_end_grant", bus.grant, 3'b000);

        // mute while steady tone plays
        bus.req = 3'b010;
        @(negedge clk);
        for (int j = 0; j <= 100; j++) begin
            chk("mute_grant", bus.grant, 3'b010);
            chk("mute_sp", 3'(bus.sp), (j >= 41 && j <= 60) ? 3'd0 : 3'(lo_sp(j)));
            if (j == 40) bus.en = 1'b0;
            if (j == 60) bus.en = 1'b1;
            @(negedge clk);
        end
        bus.req = 3'b000;
        @(negedge clk);
        chk("mute_end_grant", bus.grant, 3'b000);
        chk("mute_end_sp", 3'(bus.sp), 3'd0);

        // trigger edge on the exact final-wrap cycle chains a second beep
        bus.req = 3'b001;
        @(negedge clk);
        bus.req = 3'b000;
        for (int k = 0; k < 128; k++) begin
            chk("chain1_grant", bus.grant, 3'b001);
            chk("chain1_sp", 3'(bus.sp), 3'(hi_sp(k)));
            if (k == 127) bus.req = 3'b001;
            @(negedge clk);
        end
        bus.req = 3'b000;
        for (int k = 0; k < 128; k++) begin
            chk("chain2_grant", bus.grant, 3'b001);
            chk("chain2_sp", 3'(bus.sp), 3'(hi_sp(k)));
            // an edge while a beep is pending must not queue another one
            if (k == 50) bus.req = 3'b001;
            if (k == 51) bus.req = 3'b000;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            chk("chain_end_grant", bus.grant, 3'b000);
            chk("chain_end_sp", 3'(bus.sp), 3'd0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/buzzer_sched.md
Name: buzzer_sched

Overview:
- Single-piezo scheduler. Arbitrates three sound requesters (alarm, steady tone, key beep) onto one speaker output `sp`.
- Sequences the tone pattern of the granted source: two-tone alternating alarm, steady low tone, or fixed-length beep.
- Contains its own half-period dividers.
- Sits between the front-panel/status logic and the speaker pin.

Parameters:
- TONE_HI_HALF, 28026, half-period in clk cycles of the high tone (25 MHz / 446 / 2).
- TONE_LO_HALF, 56053, half-period in clk cycles of the low tone.
- SLOT_CYC, 6250000, clk cycles per pattern slot (250 ms at 25 MHz).
- BEEP_SLOTS, 1, number of slots a beep lasts (>=1).

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  master on/off; 0 mutes `sp` only.
- req  in  3  requests. req[2] = alarm (level). req[1] = steady tone (level). req[0] = beep trigger (rising edge).
- grant  out  3  one-hot owner of the speaker; 000 when idle.
- busy  out  1  1 when grant != 000.
- sp  out  1  speaker drive, registered.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state = IDLE, grant = 000, busy = 0, sp = 0.
  - All counters = 0, req0_q = 0, beep_pend = 0.
- Beep latch:
  - req0_q registers req[0] each cycle.
  - A rising edge (req[0] & ~req0_q) sets beep_pend.
  - beep_pend clears only when a beep completes. It survives preemption.
  - Edges arriving while beep_pend = 1 are ignored.
- States: IDLE, ALARM, STEADY, BEEP. Next state is evaluated every cycle with fixed priority:
  - req[2] -> ALARM
  - else req[1] -> STEADY
  - else beep_pend -> BEEP
  - else IDLE
- Grant latency: grant/busy reflect the new state on the first clk edge at which the winning condition is sampled true.
  - Preemption takes effect on that same edge; there is no completion wait.
- On any state change (including to IDLE):
  - tone counter = 0, slot counter = 0, sp = 0, pattern phase = 0.
  - A preempted beep restarts from slot 0 when it is re-granted.
- Tone generation:
  - The active half-period H is selected by state/phase.
  - The tone counter counts 0..H-1. At H-1 it wraps to 0 and toggles the internal tone bit.
  - Full period is 2*H cycles. The first `sp` rise occurs H edges after the state change.
- Slot counter:
  - Counts 0..SLOT_CYC-1 and wraps.
  - At each wrap, pattern phase advances, and the tone counter and tone bit reset to 0.
- Patterns:
  - ALARM: phase 0 = high tone, phase 1 = low tone, repeating.
  - STEADY: low tone always; slot wraps have no audible effect.
  - BEEP: high tone for BEEP_SLOTS slots. At the final slot wrap, beep_pend is cleared and the next state is re-evaluated on that same edge.
- Output:
  - sp = tone bit & en, registered.
  - en = 0 forces sp = 0 next cycle. The FSM and counters keep running, and grant is unaffected.
- Simultaneous events:
  - A rising edge on req[0] in the same cycle that a beep completes sets beep_pend again, so a new beep follows.
  - req[2] and req[1] rising together -> ALARM.
- Level requests dropping:
  - A level request dropping mid-tone releases the grant on the next edge.
  - sp returns to 0 on that edge.
- Widths and overflow: all counters are 32-bit unsigned; no overflow is possible for legal parameters.

Optional Feature:
- Macro: BUZZ_ALARM_GAP_EN.
- Defined: the ALARM pattern is 4 phases: high, silent, low, silent.
  - In silent phases sp = 0, the tone counter is held at 0 and the slot counter runs.
- Undefined: ALARM alternates high/low with no silent slots.
- STEADY and BEEP are identical in both builds.

Test Plan:
All scenarios use TONE_HI_HALF=4, TONE_LO_HALF=8, SLOT_CYC=64, BEEP_SLOTS=2, en=1.
- Reset:
  - Stimulus: rst_n low mid-alarm at an arbitrary cycle.
  - Response: sp, grant and busy go to 0 immediately (asynchronous). After release with req=000, everything stays 0.
- Beep:
  - Stimulus: single 1-cycle pulse on req[0].
  - Response: grant=001 on the next edge; sp is a period-8 square wave for 128 cycles; then grant=000, busy=0, sp=0.
- Alarm:
  - Stimulus: hold req[2].
  - Response: period 8 for 64 cycles, then period 16 for 64 cycles, repeating.
  - With BUZZ_ALARM_GAP_EN: period 8 / 64 cycles silence / period 16 / 64 cycles silence.
- Preemption:
  - Stimulus: beep in progress at cycle 30; assert req[1] for 100 cycles, then drop it.
  - Response: grant=010 on the next edge and sp resets, with period 16 while held. After release, the beep restarts and plays a full 128 cycles.
- Mute:
  - Stimulus: req[1] held; en=0 for 20 cycles.
  - Response: sp=0 throughout while grant stays 010. When en returns to 1, sp resumes phase-continuous with the tone counter.
- Edge case:
  - Stimulus: req[0] rises on the exact cycle a beep's final slot wraps.
  - Response: a second 128-cycle beep follows, grant=001 held, and sp holds 0 on the restart edge.
